// File: rtl/spi_cmd_bridge.sv
// spi_cmd_bridge: parses command frames arriving from an SPI slave byte
// stream, executes byte reads/writes on a local bus, and returns read data
// and status bytes through a small response FIFO to the SPI send path.
module spi_cmd_bridge #(
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 65535
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic [7:0]        tx_data,
    output logic              tx_load,
    input  logic              tx_busy,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    input  logic [7:0]        bus_rdata,
    input  logic              bus_ack,
    output logic [2:0]        err,
    output logic              idle
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [7:0] OP_WRITE  = 8'h01;
    localparam logic [7:0] OP_READ   = 8'h02;
    localparam logic [7:0] OP_STATUS = 8'h03;

    typedef enum logic [2:0] {
        IDLE, ADDR_HI, ADDR_LO, LEN, WDATA, WBUS, RBUS, DISCARD
    } state_t;

    state_t              state_reg, state_next;
    logic                is_write_reg, is_write_next;
    logic [7:0]          addr_hi_reg, addr_hi_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [8:0]          cnt_reg, cnt_next;
    logic [7:0]          wdata_reg, wdata_next;
    logic                bus_req_reg, bus_req_next;
    logic [2:0]          err_reg, err_next;
    logic [TMO_W-1:0]    tmo_reg, tmo_next;
    logic [PTR_W-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [LVL_W-1:0]    level_reg, level_next;
    logic [7:0]          tx_data_reg;
    logic                tx_load_reg;
    logic                load_d1_reg;

    logic [7:0]          fifo_mem [FIFO_DEPTH];

    logic                ack_take;
    logic                fifo_full;
    logic                pop;
    logic                can_push;
    logic                push_req;
    logic                push_ok;
    logic [7:0]          push_data;
    logic [4:0]          level_sat;
    logic [15:0]         frame_addr;

    assign ack_take   = bus_ack && bus_req_reg;
    assign fifo_full  = (level_reg == LVL_W'(FIFO_DEPTH));
    // Load the SPI only when it is free and no load happened in the last two
    // cycles, since its busy flag appears one cycle after a load.
    assign pop        = (level_reg != '0) && !tx_busy && !tx_load_reg && !load_d1_reg;
    assign can_push   = !fifo_full || pop;
    assign push_ok    = push_req && can_push;
    assign level_sat  = (32'(level_reg) > 31) ? 5'd31 : 5'(level_reg);
    assign frame_addr = {addr_hi_reg, rx_data};

    // Frame parser, bus sequencing, timeout and error bookkeeping.
    always_comb begin
        state_next    = state_reg;
        is_write_next = is_write_reg;
        addr_hi_next  = addr_hi_reg;
        addr_next     = addr_reg;
        cnt_next      = cnt_reg;
        wdata_next    = wdata_reg;
        err_next      = err_reg;
        tmo_next      = tmo_reg;
        push_req      = 1'b0;
        push_data     = 8'h00;

        case (state_reg)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                        is_write_next = (rx_data == OP_WRITE);
                        state_next    = ADDR_HI;
                    end else if (rx_data == OP_STATUS) begin
                        push_req  = 1'b1;
                        push_data = {err_reg, level_sat};
                        // Errors are only cleared once the status actually got queued.
                        if (can_push) begin
                            err_next = 3'b000;
                        end
                    end else begin
                        err_next[0] = 1'b1;
                        state_next  = DISCARD;
                    end
                end
            end
            ADDR_HI: begin
                if (rx_valid) begin
                    addr_hi_next = rx_data;
                    state_next   = ADDR_LO;
                end
            end
            ADDR_LO: begin
                if (rx_valid) begin
                    addr_next  = frame_addr[ADDR_W-1:0];
                    state_next = LEN;
                end
            end
            LEN: begin
                if (rx_valid) begin
                    // A length byte of zero encodes 256 transfers.
                    cnt_next   = {(rx_data == 8'h00), rx_data};
                    state_next = is_write_reg ? WDATA : RBUS;
                end
            end
            WDATA: begin
                if (rx_valid) begin
                    wdata_next = rx_data;
                    state_next = WBUS;
                end
            end
            WBUS: begin
                if (rx_valid) begin
                    err_next[1] = 1'b1;
                end
                if (ack_take) begin
                    addr_next  = addr_reg + ADDR_W'(1);
                    cnt_next   = cnt_reg - 9'd1;
                    state_next = (cnt_reg == 9'd1) ? IDLE : WDATA;
                end
            end
            RBUS: begin
                if (rx_valid) begin
                    err_next[1] = 1'b1;
                end
                if (ack_take) begin
                    push_req   = 1'b1;
                    push_data  = bus_rdata;
                    addr_next  = addr_reg + ADDR_W'(1);
                    cnt_next   = cnt_reg - 9'd1;
                    state_next = (cnt_reg == 9'd1) ? IDLE : RBUS;
                end
            end
            DISCARD: begin
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Inter-byte timeout; bus phases do not count, and a byte arriving in
        // the expiry cycle takes precedence over the abort.
        if (rx_valid || state_reg == IDLE) begin
            tmo_next = '0;
        end else if (state_reg != WBUS && state_reg != RBUS) begin
            if (tmo_reg == TMO_W'(TIMEOUT)) begin
                state_next = IDLE;
                tmo_next   = '0;
                if (state_reg != DISCARD) begin
                    err_next[2] = 1'b1;
                end
            end else begin
                tmo_next = tmo_reg + TMO_W'(1);
            end
        end
    end

    // Bus request is registered so it rises the cycle after entering a bus
    // state, holds until acknowledged, and is withheld for reads while full.
    always_comb begin
        if (bus_req_reg) begin
            bus_req_next = !bus_ack;
        end else begin
            bus_req_next = (state_reg == WBUS) || (state_reg == RBUS && !fifo_full);
        end
    end

    // Response FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(push_ok);
        rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
        level_next  = level_reg + LVL_W'(push_ok) - LVL_W'(pop);
    end

    // Response storage; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= push_data;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            is_write_reg <= 1'b0;
            addr_hi_reg  <= 8'h00;
            addr_reg     <= '0;
            cnt_reg      <= 9'd0;
            wdata_reg    <= 8'h00;
            bus_req_reg  <= 1'b0;
            err_reg      <= 3'b000;
            tmo_reg      <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            tx_data_reg  <= 8'h00;
            tx_load_reg  <= 1'b0;
            load_d1_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            is_write_reg <= is_write_next;
            addr_hi_reg  <= addr_hi_next;
            addr_reg     <= addr_next;
            cnt_reg      <= cnt_next;
            wdata_reg    <= wdata_next;
            bus_req_reg  <= bus_req_next;
            err_reg      <= err_next;
            tmo_reg      <= tmo_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            level_reg    <= level_next;
            tx_load_reg  <= pop;
            load_d1_reg  <= tx_load_reg;
            if (pop) begin
                tx_data_reg <= fifo_mem[rd_ptr_reg];
            end
        end
    end

    assign tx_data   = tx_data_reg;
    assign tx_load   = tx_load_reg;
    assign bus_req   = bus_req_reg;
    assign bus_we    = (state_reg == WBUS);
    assign bus_addr  = addr_reg;
    assign bus_wdata = wdata_reg;
    assign err       = err_reg;
    assign idle      = (state_reg == IDLE) && (level_reg == '0);

endmodule

// File: tb/tb_spi_cmd_bridge.sv
// Directed testbench for spi_cmd_bridge with a small bus responder and an
// SPI send-side model that raises busy for a few cycles after each load.
module tb_spi_cmd_bridge;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [7:0]  tx_data;
    logic        tx_load;
    logic        tx_busy;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata = 8'h00;
    logic        bus_ack = 1'b0;
    logic [2:0]  err;
    logic        idle;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  rd_q[$];
    logic [7:0]  tx_log[$];
    logic        bl_we[$];
    logic [15:0] bl_addr[$];
    logic [7:0]  bl_wdata[$];

    logic busy_hold = 1'b0;
    int   busy_cnt = 0;
    int   ack_wait = 0;

    assign tx_busy = busy_hold || (busy_cnt != 0);

    spi_cmd_bridge #(
        .ADDR_W(16), .FIFO_DEPTH(4), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_data(tx_data), .tx_load(tx_load), .tx_busy(tx_busy),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .err(err), .idle(idle)
    );

    always #5 clk = ~clk;

    // Bus responder (ack two negedges after req) and SPI send-side model.
    always @(negedge clk) begin
        if (!reset_n) begin
            bus_ack  = 1'b0;
            ack_wait = 0;
            busy_cnt = 0;
        end else begin
            if (tx_load) begin
                tx_log.push_back(tx_data);
                $display("tx  load  data=%02h", tx_data);
                busy_cnt = 4;
            end else if (busy_cnt != 0) begin
                busy_cnt--;
            end
            if (bus_ack) begin
                bus_ack = 1'b0;
            end else if (bus_req) begin
                if (ack_wait >= 1) begin
                    ack_wait  = 0;
                    bus_ack   = 1'b1;
                    bus_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 8'h00;
                    bl_we.push_back(bus_we);
                    bl_addr.push_back(bus_addr);
                    bl_wdata.push_back(bus_wdata);
                    $display("bus %s addr=%04h wdata=%02h rdata=%02h",
                             bus_we ? "wr" : "rd", bus_addr, bus_wdata, bus_rdata);
                end else begin
                    ack_wait++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic clear_logs();
        tx_log.delete();
        bl_we.delete();
        bl_addr.delete();
        bl_wdata.delete();
        rd_q.delete();
    endtask

    task automatic wait_done(input int ntx, input int nbus, input string name);
        int n = 0;
        while (!(idle && tx_log.size() >= ntx && bl_we.size() >= nbus) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 3000) begin
            miscompares++;
            $display("FAIL %s_wait: idle=%0b tx=%0d bus=%0d, required idle=1 tx=%0d bus=%0d",
                     name, idle, tx_log.size(), bl_we.size(), ntx, nbus);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors += 8;
        if (tx_load !== 1'b0)   begin miscompares++; $display("FAIL rst_tx_load: got %0b want 0", tx_load); end
        if (tx_data !== 8'h00)  begin miscompares++; $display("FAIL rst_tx_data: got %02h want 00", tx_data); end
        if (bus_req !== 1'b0)   begin miscompares++; $display("FAIL rst_bus_req: got %0b want 0", bus_req); end
        if (bus_we !== 1'b0)    begin miscompares++; $display("FAIL rst_bus_we: got %0b want 0", bus_we); end
        if (bus_addr !== 16'h0) begin miscompares++; $display("FAIL rst_bus_addr: got %04h want 0000", bus_addr); end
        if (bus_wdata !== 8'h0) begin miscompares++; $display("FAIL rst_bus_wdata: got %02h want 00", bus_wdata); end
        if (err !== 3'b000)     begin miscompares++; $display("FAIL rst_err: got %03b want 000", err); end
        if (idle !== 1'b1)      begin miscompares++; $display("FAIL rst_idle: got %0b want 1", idle); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_write();
        logic [15:0] ea [2] = '{16'h1234, 16'h1235};
        logic [7:0]  ed [2] = '{8'hAA, 8'hBB};
        clear_logs();
        send(8'h01, 8); send(8'h12, 8); send(8'h34, 8); send(8'h02, 8);
        send(8'hAA, 8); send(8'hBB, 8);
        wait_done(0, 2, "write");
        vectors++;
        if (bl_we.size() != 2) begin miscompares++; $display("FAIL write_count: got %0d want 2", bl_we.size()); end
        for (int i = 0; i < 2; i++) begin
            if (i < bl_we.size()) begin
                vectors++;
                if (bl_we[i] !== 1'b1 || bl_addr[i] !== ea[i] || bl_wdata[i] !== ed[i]) begin
                    miscompares++;
                    $display("FAIL write_op%0d: got we=%0b addr=%04h data=%02h want we=1 addr=%04h data=%02h",
                             i, bl_we[i], bl_addr[i], bl_wdata[i], ea[i], ed[i]);
                end
            end
        end
        vectors += 2;
        if (err !== 3'b000) begin miscompares++; $display("FAIL write_err: got %03b want 000", err); end
        if (idle !== 1'b1)  begin miscompares++; $display("FAIL write_idle: got %0b want 1", idle); end
    endtask

    task automatic test_read_wrap();
        logic [15:0] ea [3] = '{16'hFFFF, 16'h0000, 16'h0001};
        logic [7:0]  ed [3] = '{8'h11, 8'h22, 8'h33};
        clear_logs();
        rd_q.push_back(8'h11); rd_q.push_back(8'h22); rd_q.push_back(8'h33);
        send(8'h02, 8); send(8'hFF, 8); send(8'hFF, 8); send(8'h03, 0);
        wait_done(3, 3, "read");
        vectors += 2;
        if (bl_we.size() != 3)  begin miscompares++; $display("FAIL read_bus_count: got %0d want 3", bl_we.size()); end
        if (tx_log.size() != 3) begin miscompares++; $display("FAIL read_tx_count: got %0d want 3", tx_log.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < bl_we.size()) begin
                vectors++;
                if (bl_we[i] !== 1'b0 || bl_addr[i] !== ea[i]) begin
                    miscompares++;
                    $display("FAIL read_op%0d: got we=%0b addr=%04h want we=0 addr=%04h", i, bl_we[i], bl_addr[i], ea[i]);
                end
            end
            if (i < tx_log.size()) begin
                vectors++;
                if (tx_log[i] !== ed[i]) begin
                    miscompares++;
                    $display("FAIL read_tx%0d: got %02h want %02h", i, tx_log[i], ed[i]);
                end
            end
        end
        vectors++;
        if (err !== 3'b000) begin miscompares++; $display("FAIL read_err: got %03b want 000", err); end
    endtask

    task automatic test_fifo_stall();
        clear_logs();
        for (int i = 0; i < 8; i++) rd_q.push_back(8'h80 + 8'(i));
        busy_hold = 1'b1;
        send(8'h02, 8); send(8'h00, 8); send(8'h00, 8); send(8'h08, 0);
        repeat (60) @(negedge clk);
        vectors += 4;
        if (bl_we.size() != 4)  begin miscompares++; $display("FAIL stall_reads: got %0d want 4", bl_we.size()); end
        if (bus_req !== 1'b0)   begin miscompares++; $display("FAIL stall_req: got %0b want 0", bus_req); end
        if (tx_log.size() != 0) begin miscompares++; $display("FAIL stall_tx: got %0d want 0", tx_log.size()); end
        if (idle !== 1'b0)      begin miscompares++; $display("FAIL stall_idle: got %0b want 0", idle); end
        busy_hold = 1'b0;
        wait_done(8, 8, "stall");
        vectors += 2;
        if (bl_we.size() != 8)  begin miscompares++; $display("FAIL stall_bus_total: got %0d want 8", bl_we.size()); end
        if (tx_log.size() != 8) begin miscompares++; $display("FAIL stall_tx_total: got %0d want 8", tx_log.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < bl_we.size() && i < tx_log.size()) begin
                vectors++;
                if (bl_addr[i] !== 16'(i) || bl_we[i] !== 1'b0 || tx_log[i] !== 8'h80 + 8'(i)) begin
                    miscompares++;
                    $display("FAIL stall_item%0d: got addr=%04h we=%0b tx=%02h want addr=%04h we=0 tx=%02h",
                             i, bl_addr[i], bl_we[i], tx_log[i], 16'(i), 8'h80 + 8'(i));
                end
            end
        end
    endtask

    task automatic test_discard_timeout();
        clear_logs();
        send(8'h7E, 8);
        vectors += 2;
        if (err !== 3'b001) begin miscompares++; $display("FAIL discard_err: got %03b want 001", err); end
        if (idle !== 1'b0)  begin miscompares++; $display("FAIL discard_busy: got idle=%0b want 0", idle); end
        repeat (TMO + 5) @(negedge clk);
        vectors += 2;
        if (idle !== 1'b1)  begin miscompares++; $display("FAIL discard_exit_idle: got %0b want 1", idle); end
        if (err !== 3'b001) begin miscompares++; $display("FAIL discard_exit_err: got %03b want 001", err); end
        send(8'h03, 8);
        vectors += 3;
        if (tx_log.size() != 1) begin miscompares++; $display("FAIL status1_count: got %0d want 1", tx_log.size()); end
        else if (tx_log[0] !== 8'h20) begin miscompares++; $display("FAIL status1_byte: got %02h want 20", tx_log[0]); end
        if (err !== 3'b000) begin miscompares++; $display("FAIL status1_clear: got %03b want 000", err); end
        if (idle !== 1'b1)  begin miscompares++; $display("FAIL status1_idle: got %0b want 1", idle); end
    endtask

    task automatic test_write_timeout();
        clear_logs();
        send(8'h01, 8); send(8'h00, 8); send(8'h10, 8); send(8'h01, 8);
        vectors++;
        if (idle !== 1'b0) begin miscompares++; $display("FAIL wtmo_pending: got idle=%0b want 0", idle); end
        repeat (TMO) @(negedge clk);
        vectors += 4;
        if (err !== 3'b100)     begin miscompares++; $display("FAIL wtmo_err: got %03b want 100", err); end
        if (idle !== 1'b1)      begin miscompares++; $display("FAIL wtmo_idle: got %0b want 1", idle); end
        if (bus_req !== 1'b0)   begin miscompares++; $display("FAIL wtmo_req: got %0b want 0", bus_req); end
        if (bl_we.size() != 0)  begin miscompares++; $display("FAIL wtmo_bus: got %0d ops want 0", bl_we.size()); end
        send(8'h03, 8);
        vectors += 2;
        if (tx_log.size() != 1) begin miscompares++; $display("FAIL status2_count: got %0d want 1", tx_log.size()); end
        else if (tx_log[0] !== 8'h80) begin miscompares++; $display("FAIL status2_byte: got %02h want 80", tx_log[0]); end
        if (err !== 3'b000) begin miscompares++; $display("FAIL status2_clear: got %03b want 000", err); end
    endtask

    task automatic test_overrun();
        clear_logs();
        send(8'h01, 8); send(8'h00, 8); send(8'h20, 8); send(8'h01, 8);
        send(8'h5C, 0);
        send(8'hEE, 8);
        wait_done(0, 1, "overrun");
        vectors += 2;
        if (bl_we.size() != 1) begin miscompares++; $display("FAIL ovr_count: got %0d want 1", bl_we.size()); end
        else if (bl_we[0] !== 1'b1 || bl_addr[0] !== 16'h0020 || bl_wdata[0] !== 8'h5C) begin
            miscompares++;
            $display("FAIL ovr_op: got we=%0b addr=%04h data=%02h want we=1 addr=0020 data=5C",
                     bl_we[0], bl_addr[0], bl_wdata[0]);
        end
        if (err !== 3'b010) begin miscompares++; $display("FAIL ovr_err: got %03b want 010", err); end
        send(8'h03, 8);
        vectors += 2;
        if (tx_log.size() != 1) begin miscompares++; $display("FAIL status3_count: got %0d want 1", tx_log.size()); end
        else if (tx_log[0] !== 8'h40) begin miscompares++; $display("FAIL status3_byte: got %02h want 40", tx_log[0]); end
        if (err !== 3'b000) begin miscompares++; $display("FAIL status3_clear: got %03b want 000", err); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_logs();
        send(8'h01, 8); send(8'h00, 8); send(8'h00, 8); send(8'h01, 8);
        send(8'h55, 0);
        while (n < 20) begin
            @(posedge clk);
            #1;
            if (bus_req === 1'b1) break;
            n++;
        end
        vectors++;
        if (bus_req !== 1'b1) begin miscompares++; $display("FAIL rmid_req_rise: got %0b want 1", bus_req); end
        reset_n = 1'b0;
        #1;
        vectors += 3;
        if (bus_req !== 1'b0) begin miscompares++; $display("FAIL rmid_req_drop: got %0b want 0", bus_req); end
        if (idle !== 1'b1)    begin miscompares++; $display("FAIL rmid_idle: got %0b want 1", idle); end
        if (bus_we !== 1'b0)  begin miscompares++; $display("FAIL rmid_we: got %0b want 0", bus_we); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (bl_we.size() != 0) begin miscompares++; $display("FAIL rmid_no_op: got %0d ops want 0", bl_we.size()); end
        clear_logs();
        send(8'h01, 8); send(8'h00, 8); send(8'h00, 8); send(8'h01, 8); send(8'h55, 8);
        wait_done(0, 1, "after_reset");
        vectors += 2;
        if (bl_we.size() != 1) begin miscompares++; $display("FAIL rmid_count: got %0d want 1", bl_we.size()); end
        else if (bl_we[0] !== 1'b1 || bl_addr[0] !== 16'h0000 || bl_wdata[0] !== 8'h55) begin
            miscompares++;
            $display("FAIL rmid_op: got we=%0b addr=%04h data=%02h want we=1 addr=0000 data=55",
                     bl_we[0], bl_addr[0], bl_wdata[0]);
        end
        if (err !== 3'b000) begin miscompares++; $display("FAIL rmid_err: got %03b want 000", err); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wrap();
        test_fifo_stall();
        test_discard_timeout();
        test_write_timeout();
        test_overrun();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
